// File: rtl/periph_bus_responder.sv
// Peripheral slave in the address[8]=1 window: LED register, synchronized switches,
// sticky button-edge capture and a prescaled down-counting timer with interrupt.
module periph_bus_responder #(
    parameter int PRESCALE  = 50,
    parameter int SW_WIDTH  = 16,
    parameter int LED_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          address,
    input  logic [63:0]          data_in,
    input  logic                 write,
    output logic [63:0]          data_out,
    input  logic [SW_WIDTH-1:0]  switches,
    input  logic                 button,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 irq
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [LED_WIDTH-1:0] led_q;
    logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
    logic                 btn_s1, btn_s2, btn_s3;
    logic [31:0]          load_q, count_q;
    logic [3:0]           ctrl_q;
    logic [1:0]           status_q;
    logic [PW-1:0]        presc_q;

    logic       sel, we;
    logic [7:0] idx;
    logic       we_led, we_load, we_ctrl, we_status;
    logic       tick, expire, btn_edge;
    logic       unused_hi;

    assign sel       = address[8] & (address[31:9] == 23'd0);
    assign we        = write & sel;
    assign idx       = address[7:0];
    assign we_led    = we & (idx == 8'h00);
    assign we_load   = we & (idx == 8'h02);
    assign we_ctrl   = we & (idx == 8'h03);
    assign we_status = we & (idx == 8'h05);
    assign unused_hi = ^data_in[63:32];

    assign tick     = ctrl_q[0] & (presc_q == PMAX);
    assign expire   = tick & (count_q == 32'd0);
    assign btn_edge = btn_s2 & ~btn_s3;
    assign leds     = led_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q    <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_s3   <= 1'b0;
            load_q   <= '0;
            count_q  <= '0;
            ctrl_q   <= '0;
            status_q <= '0;
            presc_q  <= '0;
            irq      <= 1'b0;
        end else begin
            sw_s1  <= switches;
            sw_s2  <= sw_s1;
            btn_s1 <= button;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;

            if (we_led) led_q <= data_in[LED_WIDTH-1:0];

            if (we_load || !ctrl_q[0] || tick) presc_q <= '0;
            else                               presc_q <= presc_q + PW'(1);

            // A LOAD write overrides whatever the tick would have done to COUNT.
            if (we_load) begin
                load_q  <= data_in[31:0];
                count_q <= data_in[31:0];
            end else if (tick) begin
                if (count_q != 32'd0) count_q <= count_q - 32'd1;
                else if (ctrl_q[1])   count_q <= load_q;
            end

            if (we_ctrl)                    ctrl_q    <= data_in[3:0];
            else if (expire && !ctrl_q[1]) ctrl_q[0] <= 1'b0;

            // Hardware set beats a same-cycle write-1-clear.
            status_q <= (status_q & ~(we_status ? data_in[1:0] : 2'b00))
                      | {btn_edge, expire};

            irq <= (status_q[0] & ctrl_q[2]) | (status_q[1] & ctrl_q[3]);
        end
    end

    always_comb begin
        data_out = 64'd0;
        if (sel) begin
            case (idx)
                8'h00:   data_out = 64'(led_q);
                8'h01:   data_out = 64'(sw_s2);
                8'h02:   data_out = 64'(load_q);
                8'h03:   data_out = 64'(ctrl_q);
                8'h04:   data_out = 64'(count_q);
                8'h05:   data_out = 64'(status_q);
                default: data_out = 64'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_periph_bus_responder.sv
// Bench for periph_bus_responder: directed scenarios plus randomized bus traffic
// checked against a behavioural model of the register map.
module tb_periph_bus_responder;
    localparam int PRESCALE = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = 32'd0;
    logic [63:0] data_in = 64'd0;
    logic        write = 1'b0;
    logic [63:0] data_out;
    logic [15:0] switches = 16'd0;
    logic        button = 1'b0;
    logic [15:0] leds;
    logic        irq;

    int tests = 0;
    int fails = 0;

    periph_bus_responder #(.PRESCALE(PRESCALE), .SW_WIDTH(16), .LED_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .address(address), .data_in(data_in),
        .write(write), .data_out(data_out), .switches(switches), .button(button),
        .leds(leds), .irq(irq)
    );

    always #5 clock = ~clock;

    // Behavioural model state; sw_h/btn_h hold input samples from recent edges (0 = newest).
    logic [15:0] m_led;
    logic [31:0] m_load, m_count;
    logic [3:0]  m_ctrl;
    logic [1:0]  m_status;
    logic        m_irq;
    int          m_phase;
    logic [15:0] sw_h [0:2];
    logic        btn_h [0:2];

    task automatic model_reset();
        m_led = 0; m_load = 0; m_count = 0; m_ctrl = 0; m_status = 0; m_irq = 0; m_phase = 0;
        for (int i = 0; i < 3; i++) begin sw_h[i] = 0; btn_h[i] = 0; end
    endtask

    function automatic logic model_tick();
        return m_ctrl[0] && (m_phase == PRESCALE - 1);
    endfunction

    function automatic logic [63:0] exp_read(input logic [31:0] a);
        if (!(a[8] && a[31:9] == 0)) return 64'd0;
        case (a[7:0])
            8'h00:   return {48'd0, m_led};
            8'h01:   return {48'd0, sw_h[1]};
            8'h02:   return {32'd0, m_load};
            8'h03:   return {60'd0, m_ctrl};
            8'h04:   return {32'd0, m_count};
            8'h05:   return {62'd0, m_status};
            default: return 64'd0;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        logic        we_, tk, tset, bset;
        logic [7:0]  ix;
        logic [3:0]  nctrl;
        logic [31:0] ncount;
        logic [1:0]  nstat;
        int          nphase;
        we_   = write && address[8] && (address[31:9] == 0);
        ix    = address[7:0];
        tk    = model_tick();
        bset  = btn_h[1] && !btn_h[2];
        nphase = (!m_ctrl[0] || tk) ? 0 : m_phase + 1;
        ncount = m_count; nctrl = m_ctrl; tset = 0; nstat = m_status;
        if (tk) begin
            if (m_count != 0) ncount = m_count - 1;
            else begin
                tset = 1;
                if (m_ctrl[1]) ncount = m_load; else nctrl[0] = 0;
            end
        end
        m_irq = (m_status[0] && m_ctrl[2]) || (m_status[1] && m_ctrl[3]);
        if (we_) case (ix)
            8'h00: m_led = data_in[15:0];
            8'h02: begin m_load = data_in[31:0]; ncount = data_in[31:0]; nphase = 0; end
            8'h03: nctrl = data_in[3:0];
            8'h05: nstat = nstat & ~data_in[1:0];
            default: ;
        endcase
        m_status = nstat | {bset, tset};
        m_count = ncount; m_ctrl = nctrl; m_phase = nphase;
        btn_h[2] = btn_h[1]; btn_h[1] = btn_h[0]; btn_h[0] = button;
        sw_h[2] = sw_h[1]; sw_h[1] = sw_h[0]; sw_h[0] = switches;
    endtask

    task automatic clk();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        address = a; data_in = d; write = 1'b1;
        clk();
        write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        reset = 1'b0;
        model_reset();
        #2 reset = 1'b1;
        clk();
        for (int i = 0; i < 7; i++) begin
            a = (i == 6) ? 32'h1FF : 32'h100 + i;
            address = a; #1;
            tests++;
            if (data_out !== 64'd0) begin
                fails++; $display("FAIL reset_read[%h]: got %h expected 0", a, data_out);
            end
        end
        tests++;
        if (leds !== 16'd0 || irq !== 1'b0) begin
            fails++; $display("FAIL reset_outs: leds=%h irq=%b expected 0/0", leds, irq);
        end
    endtask

    task automatic test_led();
        wr(32'h100, 64'hFFFF_0000_0000_ABCD);
        tests++;
        if (leds !== 16'hABCD) begin fails++; $display("FAIL led_write: got %h expected abcd", leds); end
        wr(32'h000, 64'h1234);
        tests++;
        if (leds !== 16'hABCD) begin fails++; $display("FAIL led_ram_window: got %h expected abcd", leds); end
        wr(32'h300, 64'h5555);
        tests++;
        if (leds !== 16'hABCD) begin fails++; $display("FAIL led_high_addr: got %h expected abcd", leds); end
        address = 32'h000; #1;
        tests++;
        if (data_out !== 64'd0) begin fails++; $display("FAIL read_unselected: got %h expected 0", data_out); end
        address = 32'h100; #1;
        tests++;
        if (data_out !== 64'hABCD) begin fails++; $display("FAIL led_read: got %h expected abcd", data_out); end
    endtask

    task automatic test_oneshot();
        logic [31:0] seq[$];
        int k;
        wr(32'h102, 64'd3);
        wr(32'h103, 64'h5);
        k = 0;
        while (!m_status[0] && k < 40) begin
            address = 32'h104; #1;
            tests++;
            if (data_out !== exp_read(address)) begin
                fails++; $display("FAIL oneshot_count: got %h expected %h", data_out, exp_read(address));
            end
            if (seq.size() == 0 || seq[$] != data_out[31:0]) seq.push_back(data_out[31:0]);
            clk(); k++;
        end
        tests++;
        if (k != 4 * PRESCALE || seq.size() != 4 || seq[0] != 3 || seq[1] != 2 || seq[2] != 1 || seq[3] != 0) begin
            fails++; $display("FAIL oneshot_sequence: %0d cycles %0d values, expected 8 cycles 3,2,1,0", k, seq.size());
        end
        address = 32'h105; #1;
        tests++;
        if (data_out !== 64'd1 || irq !== 1'b0) begin
            fails++; $display("FAIL texp_set: status=%h irq=%b expected 1/0", data_out, irq);
        end
        clk(); clk(); clk();
        address = 32'h103; #1;
        tests++;
        if (data_out !== 64'h4 || irq !== 1'b1) begin
            fails++; $display("FAIL oneshot_stop: ctrl=%h irq=%b expected 4/1", data_out, irq);
        end
        address = 32'h104; #1;
        tests++;
        if (data_out !== 64'd0) begin fails++; $display("FAIL oneshot_hold: got %h expected 0", data_out); end
        wr(32'h105, 64'h1);
        address = 32'h105; #1;
        tests++;
        if (data_out !== 64'd0 || irq !== 1'b1) begin
            fails++; $display("FAIL texp_clear: status=%h irq=%b expected 0/1", data_out, irq);
        end
        clk();
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_deassert: got %b expected 0", irq); end
    endtask

    task automatic test_auto();
        int n;
        wr(32'h102, 64'd1);
        wr(32'h103, 64'h3);
        for (int i = 0; i < 24; i++) begin
            address = 32'h104; #1;
            tests++;
            if (data_out !== exp_read(address)) begin
                fails++; $display("FAIL auto_count: got %h expected %h", data_out, exp_read(address));
            end
            clk();
        end
        n = 0;
        while (model_tick() && m_count == 0 && n < 20) begin clk(); n++; end
        wr(32'h105, 64'h1);
        address = 32'h105; #1;
        tests++;
        if (data_out[0] !== 1'b0) begin fails++; $display("FAIL auto_clear_idle: got %h expected 0", data_out); end
        n = 0;
        while (!(model_tick() && m_count == 0) && n < 20) begin clk(); n++; end
        wr(32'h105, 64'h1);
        address = 32'h105; #1;
        tests++;
        if (data_out[0] !== 1'b1 || n >= 20) begin
            fails++; $display("FAIL set_beats_clear: got %h expected 1", data_out);
        end
        wr(32'h103, 64'h0);
        wr(32'h105, 64'h3);
    endtask

    task automatic test_button();
        wr(32'h103, 64'h8);
        button = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            clk();
            if (i == 1) button = 1'b0;
            address = 32'h105; #1;
            tests++;
            if (data_out[1] !== (i >= 3) || irq !== (i >= 4)) begin
                fails++; $display("FAIL bedge_latency[%0d]: bedge=%b irq=%b expected %b/%b", i, data_out[1], irq, i >= 3, i >= 4);
            end
        end
        wr(32'h105, 64'h2);
        clk(); clk();
        button = 1'b1;
        for (int i = 0; i < 100; i++) clk();
        address = 32'h105; #1;
        tests++;
        if (data_out[1] !== 1'b1) begin fails++; $display("FAIL bedge_hold: got %b expected 1", data_out[1]); end
        wr(32'h105, 64'h2);
        for (int i = 0; i < 10; i++) clk();
        address = 32'h105; #1;
        tests++;
        if (data_out[1] !== 1'b0 || irq !== 1'b0) begin
            fails++; $display("FAIL bedge_single: bedge=%b irq=%b expected 0/0", data_out[1], irq);
        end
        button = 1'b0;
        wr(32'h103, 64'h0);
        for (int i = 0; i < 4; i++) clk();
        wr(32'h105, 64'h3);
    endtask

    task automatic test_switches();
        logic [15:0] want;
        switches = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            address = 32'h101; #1;
            want = (i == 2) ? 16'h1234 : 16'h0000;
            tests++;
            if (data_out !== {48'd0, want}) begin
                fails++; $display("FAIL sw_sync[%0d]: got %h expected %h", i, data_out, want);
            end
            clk();
        end
    endtask

    task automatic test_reset_mid();
        wr(32'h102, 64'd0);
        wr(32'h103, 64'h7);
        clk(); clk(); clk();
        wr(32'h102, 64'd50);
        for (int i = 0; i < 10; i++) clk();
        address = 32'h104; #1;
        tests++;
        if (irq !== 1'b1 || data_out !== exp_read(address) || data_out == 64'd0) begin
            fails++; $display("FAIL pre_reset_run: count=%h irq=%b expected %h/1", data_out, irq, exp_read(address));
        end
        #1 reset = 1'b0;
        model_reset();
        #1;
        address = 32'h104; #1;
        tests++;
        if (data_out !== 64'd0 || irq !== 1'b0 || leds !== 16'd0) begin
            fails++; $display("FAIL async_reset: count=%h irq=%b leds=%h expected 0", data_out, irq, leds);
        end
        address = 32'h103; #1;
        tests++;
        if (data_out !== 64'd0) begin fails++; $display("FAIL async_reset_ctrl: got %h expected 0", data_out); end
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) clk();
        address = 32'h104; #1;
        tests++;
        if (data_out !== 64'd0) begin fails++; $display("FAIL stays_stopped: got %h expected 0", data_out); end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                6:       address = 32'h1FF;
                7:       address = {24'd0, 8'($urandom)};
                8:       address = 32'h300;
                9:       address = 32'h106;
                default: address = 32'h100 + r;
            endcase
            write = ($urandom_range(0, 2) == 0);
            data_in = {$urandom, $urandom};
            if (r == 2) data_in[31:0] = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) button = ~button;
            if ($urandom_range(0, 15) == 0) switches = 16'($urandom);
            #1;
            tests++;
            if (data_out !== exp_read(address) || leds !== m_led || irq !== m_irq) begin
                fails++;
                $display("FAIL random[%0d] addr %h: data=%h leds=%h irq=%b expected %h/%h/%b",
                         i, address, data_out, leds, irq, exp_read(address), m_led, m_irq);
            end
            clk();
        end
        write = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_led();
        test_oneshot();
        test_auto();
        test_button();
        test_switches();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/periph_bus_responder.md
Name: periph_bus_responder

Overview:
- Memory-mapped peripheral slave on the CPU data bus. It occupies the peripheral address window, where address[8]=1; RAM owns the window where address[8]=0.
- Consumes the datapath's ALU address, Databus write data and Write strobe.
- Returns read data on data_out, which feeds the datapath's peripheral data_in.
- Contains an LED output register, synchronized switch/button inputs with sticky button-edge capture, and a prescaled 32-bit down-counting timer with reload and interrupt.

Parameters:
PRESCALE, 50, clocks per timer tick (>=1)
SW_WIDTH, 16, switch input width
LED_WIDTH, 16, LED output width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
address  input  32  bus address (ALU output); word index = address[7:0]
data_in  input  64  write data (Databus)
write  input  1  memory write strobe; not pre-qualified by address
data_out  output  64  combinational read data
switches  input  SW_WIDTH  raw asynchronous switches
button  input  1  raw asynchronous pushbutton
leds  output  LED_WIDTH  LED register
irq  output  1  level interrupt

Behaviour:
- sel = address[8] & (address[31:9]==0). Write enable we = write & sel. Writes with sel=0 are ignored.
- Register map (word index, with address[8]=1):
  - 0x100 LED: RW; low LED_WIDTH bits.
  - 0x101 SW: RO; 2-flop-synchronized switches, zero-extended.
  - 0x102 LOAD: RW 32-bit. A write also loads COUNT with data_in[31:0] and clears the prescaler.
  - 0x103 CTRL: RW; bit0 EN, bit1 AUTO (auto-reload), bit2 TIE (timer irq enable), bit3 BIE (button irq enable).
  - 0x104 COUNT: RO 32-bit.
  - 0x105 STATUS: bit0 TEXP, bit1 BEDGE. Both are sticky. Write-1-to-clear per bit; writing 0 has no effect.
  - All other indices: read 0; writes ignored.
- Reads: data_out is a combinational mux of address[7:0] and is 0 when sel=0. There is no read side effect, because the bus has no read strobe.
- Reset (reset=0, asynchronous): LED=0, LOAD=0, CTRL=0, COUNT=0, prescaler=0, STATUS=0, synchronizer flops=0, irq=0.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN=1; holds at 0 while EN=0.
  - tick=1 in the cycle the prescaler equals PRESCALE-1, after which it wraps to 0.
- Timer, evaluated on tick:
  - COUNT>0: COUNT decrements by 1.
  - COUNT==0: TEXP set.
    - AUTO=1: COUNT<=LOAD and EN stays 1.
    - AUTO=0: EN cleared by hardware and COUNT holds 0.
- Enabling with COUNT=0 and LOAD=0 under AUTO=1: TEXP sets every tick. This is legal.
- Button input:
  - Synchronized with 2 flops, then a third registered copy is used for edge detect.
  - A rising edge (sync=1, prev=0) sets BEDGE. Latency from a raw button rise to BEDGE=1 is 3 clocks.
- Simultaneous events:
  - Hardware set and a write-1-clear of the same STATUS bit in the same cycle: set wins.
  - Write to LOAD in the same cycle as a tick: the write wins; COUNT=new value and the prescaler restarts.
  - Write to CTRL in the same cycle as hardware EN-clear: the written value wins.
- irq = (TEXP & TIE) | (BEDGE & BIE), registered. It asserts 1 clock after the flag sets and deasserts 1 clock after the flag clears.
- Reset mid-count: all state is cleared immediately. The timer stays stopped until it is re-enabled by software.
- Bits of data_in above each register's width are ignored. Read values are zero-extended.

Test Plan:
- Reset, then read indices 0x100..0x105 and 0x1FF -> all 0; leds=0; irq=0. Then write 0x0000_ABCD to 0x100 -> leds=16'hABCD. Write to 0x000 with write=1 -> leds unchanged.
- PRESCALE=2. Write LOAD=3, then CTRL=0x5 (EN, TIE, AUTO=0):
  - COUNT reads 3, 2, 1, 0 on successive 2-clock ticks.
  - TEXP sets on the next tick, irq=1 one clock later, EN reads 0, and COUNT holds 0.
  - Write STATUS=1 -> TEXP=0, irq=0 next clock.
- AUTO reload: LOAD=1, CTRL=0x3 -> COUNT sequence 1, 0, 1, 0, ... and TEXP set once per 2 ticks. Issue a write-1-clear in the same cycle as an expiry tick -> TEXP remains 1.
- Button: raise button for 1 clock -> BEDGE=1 exactly 3 clocks later. With BIE=1, irq follows 1 clock after that. Holding button high 100 clocks -> exactly one edge captured; after a clear, BEDGE stays 0.
- Switches=0x1234 applied -> SW read returns 0 for 2 clocks, then 0x1234. Assert reset low mid-timer-run -> COUNT=0, CTRL=0, irq=0 asynchronously, before the next clock edge.
